sdes_core_ctrl: RTL

- Iterative S-DES encrypt/decrypt engine with a valid/ready handshake on input and output.
- Owns the S-DES round sequencing FSM and the 10-bit key schedule.
- Time-shares a single F-function datapath, built on the existing S0/S1 S-box modules, across both rounds.
- Sits between the host-side block source and the result sink; one 8-bit block in flight at a time.

---
 rtl/sdes_pkg.sv | 97 +++++++++
 rtl/sdes_core_ctrl_if.sv | 27 ++
 rtl/sdes_fk.sv | 31 +++
 rtl/sdes_sbox.sv | 29 ++
 rtl/sdes_core_ctrl.sv | 128 ++++++++++++
 5 files changed

// File: rtl/sdes_pkg.sv
// S-DES shared types, permutation tables and helpers.
// All block/key vectors are [0:N-1] so index 0 is S-DES bit 1.
package sdes_pkg;

  localparam int BLK_W = 8;
  localparam int KEY_W = 10;

  typedef logic [0:BLK_W-1] blk_t;
  typedef logic [0:KEY_W-1] key_t;
  typedef logic [0:3]       nib_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_R1,
    S_R2,
    S_OUT
  } state_e;

  // 1-based source positions; unused tail entries point at bit 1
  typedef logic [0:9][3:0] ptab_t;

  localparam ptab_t P10 = '{
    4'd3, 4'd5, 4'd2, 4'd7, 4'd4,
    4'd10, 4'd1, 4'd9, 4'd8, 4'd6
  };
  localparam ptab_t P8 = '{
    4'd6, 4'd3, 4'd7, 4'd4, 4'd8,
    4'd5, 4'd10, 4'd9, 4'd1, 4'd1
  };
  localparam ptab_t IP = '{
    4'd2, 4'd6, 4'd3, 4'd1, 4'd4,
    4'd8, 4'd5, 4'd7, 4'd1, 4'd1
  };
  localparam ptab_t IP_INV = '{
    4'd4, 4'd1, 4'd3, 4'd5, 4'd7,
    4'd2, 4'd8, 4'd6, 4'd1, 4'd1
  };
  localparam ptab_t EP = '{
    4'd4, 4'd1, 4'd2, 4'd3, 4'd2,
    4'd3, 4'd4, 4'd1, 4'd1, 4'd1
  };
  localparam ptab_t P4 = '{
    4'd2, 4'd4, 4'd3, 4'd1, 4'd1,
    4'd1, 4'd1, 4'd1, 4'd1, 4'd1
  };

  function automatic logic permute(
    input logic [0:9] src,
    input logic [3:0] pos
  );
    return src[pos - 4'd1];
  endfunction

  function automatic key_t perm_p10(input key_t k);
    key_t r;
    for (int j = 0; j < 10; j++)
      r[j] = permute(k, P10[j]);
    return r;
  endfunction

  function automatic blk_t perm_p8(input key_t k);
    blk_t r;
    for (int j = 0; j < 8; j++)
      r[j] = permute(k, P8[j]);
    return r;
  endfunction

  function automatic blk_t perm_ip(input blk_t d);
    blk_t r;
    for (int j = 0; j < 8; j++)
      r[j] = permute({d, 2'b00}, IP[j]);
    return r;
  endfunction

  function automatic blk_t perm_ip_inv(input blk_t d);
    blk_t r;
    for (int j = 0; j < 8; j++)
      r[j] = permute({d, 2'b00}, IP_INV[j]);
    return r;
  endfunction

  function automatic blk_t perm_ep(input nib_t n);
    blk_t r;
    for (int j = 0; j < 8; j++)
      r[j] = permute({n, 6'd0}, EP[j]);
    return r;
  endfunction

  function automatic nib_t perm_p4(input nib_t n);
    nib_t r;
    for (int j = 0; j < 4; j++)
      r[j] = permute({n, 6'd0}, P4[j]);
    return r;
  endfunction

endpackage

// File: rtl/sdes_core_ctrl_if.sv
// Block-in / result-out handshake bundle for the S-DES core.
// master = host side, slave = core side.
interface sdes_core_ctrl_if;
  import sdes_pkg::*;

  logic in_valid;
  logic in_ready;
  blk_t in_data;
  key_t in_key;
  logic in_mode;
  logic out_valid;
  logic out_ready;
  blk_t out_data;

  modport master (
    output in_valid, in_data, in_key,
    output in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key,
    input  in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sdes_fk.sv
// Combinational S-DES round function fk(L, R, k).
// R passes through; L is masked by P4 of the S-box outputs.
module sdes_fk
  import sdes_pkg::*;
(
  input  blk_t d_i,
  input  blk_t k_i,
  output blk_t d_o
);

  blk_t       x;
  logic [0:1] s0;
  logic [0:1] s1;
  nib_t       p;

  assign x = perm_ep(d_i[4:7]) ^ k_i;

  sdes_s0 u_s0 (
    .x_i (x[0:3]),
    .y_o (s0)
  );

  sdes_s1 u_s1 (
    .x_i (x[4:7]),
    .y_o (s1)
  );

  assign p   = perm_p4({s0, s1});
  assign d_o = {d_i[0:3] ^ p, d_i[4:7]};

endmodule

// File: rtl/sdes_sbox.sv
// S-DES S-boxes; row = bits 1,4 and column = bits 2,3.
// Output is a 2-bit value with index 0 as its MSB.
module sdes_s0 (
  input  logic [0:3] x_i,
  output logic [0:1] y_o
);
  localparam logic [0:15][1:0] T = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };

  assign y_o = T[{x_i[0], x_i[3], x_i[1], x_i[2]}];
endmodule

module sdes_s1 (
  input  logic [0:3] x_i,
  output logic [0:1] y_o
);
  localparam logic [0:15][1:0] T = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  assign y_o = T[{x_i[0], x_i[3], x_i[1], x_i[2]}];
endmodule

// File: rtl/sdes_core_ctrl.sv
// Iterative S-DES engine: one block in flight, two rounds
// through a single shared fk datapath.
module sdes_core_ctrl
  import sdes_pkg::*;
#(
  parameter bit DECRYPT_EN  = 1'b1,
  parameter bit CLR_ON_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  sdes_core_ctrl_if.slave  bus,
  output logic             busy
);

  state_e state_q, state_d;
  blk_t   data_q, data_d;
  blk_t   ka_q, ka_d;
  blk_t   kb_q, kb_d;
  logic   mode_q, mode_d;
  blk_t   out_q, out_d;
  logic   ov_q, ov_d;

  logic   accept;
  logic   done;
  key_t   p10;
  blk_t   k1;
  blk_t   k2;
  blk_t   rk;
  blk_t   fk_d;

  assign bus.in_ready = (state_q == S_IDLE)
                      | ((state_q == S_OUT) & bus.out_ready);
  assign accept = bus.in_valid & bus.in_ready;
  assign done   = (state_q == S_OUT) & bus.out_ready;

  assign bus.out_valid = ov_q;
  assign bus.out_data  = out_q;
  assign busy          = (state_q != S_IDLE);

  // K1 uses LS1 per half, K2 the cumulative LS3
  assign p10 = perm_p10(bus.in_key);
  assign k1  = perm_p8({p10[1:4], p10[0],
                        p10[6:9], p10[5]});
  assign k2  = perm_p8({p10[3:4], p10[0:2],
                        p10[8:9], p10[5:7]});

  assign rk = (state_q == S_R1) ? ka_q : kb_q;

  sdes_fk u_fk (
    .d_i (data_q),
    .k_i (rk),
    .d_o (fk_d)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_LOAD;
      S_LOAD: state_d = S_R1;
      S_R1:   state_d = S_R2;
      S_R2:   state_d = S_OUT;
      S_OUT: begin
        if (bus.out_ready)
          state_d = bus.in_valid ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    ka_d   = ka_q;
    kb_d   = kb_q;
    mode_d = mode_q;
    out_d  = out_q;
    ov_d   = ov_q;
    if (done) ov_d = 1'b0;
    if (CLR_ON_IDLE && done && !bus.in_valid) begin
      data_d = '0;
      ka_d   = '0;
      kb_d   = '0;
      mode_d = 1'b0;
    end
    unique case (1'b1)
      accept: begin
        data_d = perm_ip(bus.in_data);
        ka_d   = k1;
        kb_d   = k2;
        mode_d = bus.in_mode & DECRYPT_EN;
      end
      (state_q == S_LOAD): begin
        if (mode_q) begin
          ka_d = kb_q;
          kb_d = ka_q;
        end
      end
      (state_q == S_R1): begin
        data_d = {fk_d[4:7], fk_d[0:3]};
      end
      (state_q == S_R2): begin
        out_d = perm_ip_inv(fk_d);
        ov_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      ka_q    <= '0;
      kb_q    <= '0;
      mode_q  <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

endmodule
